// File: rtl/rr_mux_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry output register.
// Requester A and B compete for the register, and the loser of a contended grant is preferred next time.
module rr_mux_arbiter #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            a_valid,
    input  logic [SIZE-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [SIZE-1:0] b_data,
    output logic            b_ready,
    output logic            z_valid,
    output logic [SIZE-1:0] z,
    input  logic            z_ready,
    output logic            sel,
    output logic [15:0]     a_count,
    output logic [15:0]     b_count,
    output logic            dbg_state,
    output logic            dbg_prio
);

    // Handshake: a word moves across a port on a rising edge where that port's
    // valid and ready are both 1; ready never depends on the data lines.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_prio;
    logic              r_sel;
    logic [SIZE-1:0]   r_z;
    logic [15:0]       r_a_count;
    logic [15:0]       r_b_count;

    logic              w_can_load;
    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_xfer_a;
    logic              w_xfer_b;
    logic              w_drain;

    // Contended grants go to the side named by prio.
    always_comb begin
        w_grant_a = a_valid && (!b_valid || !r_prio);
        w_grant_b = b_valid && (!a_valid ||  r_prio);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_xfer_a || w_xfer_b) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_xfer_a || w_xfer_b) begin
                    w_state_next = ST_FULL;
                end else if (z_ready) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_comb begin
        z_valid    = (r_state == ST_FULL);
        w_can_load = !z_valid || z_ready;
        a_ready    = !reset && w_can_load && w_grant_a;
        b_ready    = !reset && w_can_load && w_grant_b;
        w_xfer_a   = a_valid && a_ready;
        w_xfer_b   = b_valid && b_ready;
        w_drain    = z_valid && z_ready && !reset;
    end

    // Output word and source; both hold their last value after a drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_z   <= '0;
            r_sel <= 1'b0;
        end else if (w_xfer_a) begin
            r_z   <= a_data;
            r_sel <= 1'b0;
        end else if (w_xfer_b) begin
            r_z   <= b_data;
            r_sel <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio <= 1'b0;
        end else if (w_xfer_a) begin
            r_prio <= 1'b1;
        end else if (w_xfer_b) begin
            r_prio <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_count <= 16'h0000;
            r_b_count <= 16'h0000;
        end else begin
            if (w_xfer_a) begin
                r_a_count <= r_a_count + 16'h0001;
            end
            if (w_xfer_b) begin
                r_b_count <= r_b_count + 16'h0001;
            end
        end
    end

    assign z         = r_z;
    assign sel       = r_sel;
    assign a_count   = r_a_count;
    assign b_count   = r_b_count;
    assign dbg_state = r_state;
    assign dbg_prio  = r_prio;

    logic w_unused;
    assign w_unused = w_drain;

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter SIZE, default 32, data width of both requester ports and the output.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 a_valid  input  1  requester A offers a word.
REQ-005 a_data  input  SIZE  requester A word.
REQ-006 a_ready  output  1  A's word is accepted this cycle.
REQ-007 b_valid  input  1  requester B offers a word.
REQ-008 b_data  input  SIZE  requester B word.
REQ-009 b_ready  output  1  B's word is accepted this cycle.
REQ-010 z_valid  output  1  output register holds a word.
REQ-011 z  output  SIZE  output word.
REQ-012 z_ready  input  1  consumer takes z this cycle.
REQ-013 sel  output  1  source of the current z word: 0 = A, 1 = B (mux select convention: 0 picks first input).
REQ-014 a_count  output  16  number of A words accepted since reset.
REQ-015 b_count  output  16  number of B words accepted since reset.

Function
REQ-016 The block SHALL hold a one-entry output register (z, sel) with states EMPTY (z_valid=0) and FULL (z_valid=1).
REQ-017 Capture is permitted in a cycle iff can_load = !z_valid || z_ready.
REQ-018 Transfer on a port occurs iff that port's valid and ready are both 1 at the clock edge.
REQ-019 The block SHALL keep a priority bit prio (0 = A preferred, 1 = B preferred).
REQ-020 Grant: only A valid -> A; only B valid -> B; both valid -> the side named by prio; neither -> no grant.
REQ-021 a_ready SHALL be 1 iff can_load and A is granted; b_ready likewise for B; never both 1 in the same cycle.
REQ-022 a_ready and b_ready SHALL be combinational from the current inputs and state; they SHALL NOT depend on a_data or b_data.
REQ-023 On a transfer, z <= granted data, sel <= granted side, z_valid <= 1, one-cycle latency from accept to z_valid.
REQ-024 On a transfer, prio <= inverse of the granted side (A granted -> prio=1; B granted -> prio=0).
REQ-025 With no grant, prio SHALL be unchanged.
REQ-026 When z_valid && z_ready and no new grant, z_valid <= 0; z and sel SHALL hold their last values.
REQ-027 Simultaneous drain and capture (z_valid && z_ready and a grant) SHALL replace z in the same edge, keeping z_valid=1, sustaining one word per cycle.
REQ-028 While FULL and z_ready=0, z, sel and z_valid SHALL remain stable, and both readies SHALL be 0.
REQ-029 a_count/b_count SHALL increment by 1 on each transfer on their port and wrap from 16'hFFFF to 0.
REQ-030 A requester dropping valid before being granted SHALL not be charged a transfer or change prio.
REQ-031 With both requesters continuously valid and z_ready=1, grants SHALL strictly alternate A, B, A, B...

Reset
REQ-032 While reset=1 at a clock edge: z_valid=0, z=0, sel=0, prio=0, a_count=0, b_count=0.
REQ-033 During a reset cycle a_ready and b_ready SHALL be 0, and no transfer SHALL be counted.
REQ-034 Reset asserted while FULL SHALL discard the held word; no output handshake completes in that cycle.
REQ-035 The first cycle after reset deasserts SHALL behave as EMPTY with A preferred.

Verification
REQ-036 Reset, then a_valid=1, a_data=32'hAAAA0001, b_valid=1, b_data=32'hBBBB0001, z_ready=1 for 4 cycles -> z sequence A, B, A, B, sel 0,1,0,1; a_count=2, b_count=2.
REQ-037 Only b_valid=1, b_data=32'h12345678, z_ready=1 -> b_ready=1, next cycle z=32'h12345678, sel=1, prio=0.
REQ-038 Capture A word 32'h00000005, then z_ready=0 for 3 cycles with both valid -> z holds 32'h00000005, a_ready=b_ready=0 throughout; z_ready=1 -> B is accepted next.
REQ-039 Assert reset while z_valid=1 -> next cycle z_valid=0, z=0, counts=0, first contended grant after reset goes to A.
REQ-040 Preload a_count to 16'hFFFF via 65535 A transfers, then one more -> a_count=0, b_count unchanged.
REQ-041 Randomised 500-cycle run with a scoreboard: every accepted word appears on z exactly once in order, sel matches its source, and a_ready&&b_ready is never 1.
